// File: rtl/rib_xbar_if.sv
// Bus bundle for rib_xbar: master-side request/response and slave-side fan-out.
// The master and slave modports describe the attached agents; xbar is the crossbar's view.
interface rib_xbar_if #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
);
  logic [NUM_MASTERS-1:0]        m_req_i;
  logic [NUM_MASTERS-1:0]        m_we_i;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i;
  logic [NUM_MASTERS*DATA_W-1:0] m_data_i;
  logic [NUM_MASTERS*DATA_W-1:0] m_data_o;
  logic [NUM_MASTERS-1:0]        grant_o;
  logic [NUM_SLAVES*ADDR_W-1:0]  s_addr_o;
  logic [NUM_SLAVES*DATA_W-1:0]  s_data_o;
  logic [NUM_SLAVES-1:0]         s_we_o;
  logic [NUM_SLAVES*DATA_W-1:0]  s_data_i;
  logic                          hold_flag_o;
  logic                          dec_err_o;

  modport master (
    output m_req_i, m_we_i, m_addr_i, m_data_i,
    input  m_data_o, grant_o, hold_flag_o, dec_err_o
  );

  modport slave (
    input  s_addr_o, s_data_o, s_we_o,
    output s_data_i
  );

  modport xbar (
    input  m_req_i, m_we_i, m_addr_i, m_data_i, s_data_i,
    output m_data_o, grant_o, s_addr_o, s_data_o, s_we_o, hold_flag_o, dec_err_o
  );
endinterface

// File: rtl/rib_xbar.sv
// Registered-grant RIB crossbar: NUM_MASTERS masters onto NUM_SLAVES slaves with burst limiting.
// Define RIB_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module rib_xbar #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned MAX_BURST   = 8
) (
  input  logic     clk,
  input  logic     rst,
  rib_xbar_if.xbar bus
);
  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam int unsigned LOW_W = ADDR_W - SEL_W;
  // Counter parks at the rotation threshold so a late contender still forces rotation.
  localparam logic [CNT_W-1:0] CNT_CAP = (MAX_BURST == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_BURST - 1);

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;
`ifdef RIB_RR_EN
  logic [IDX_W-1:0]       last_q, last_d;
`endif

  logic                   gnt_any;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   cur_req;
  logic                   others_req;
  logic                   force_rot;
  logic [NUM_MASTERS-1:0] cand;
  logic                   win_vld;
  logic [IDX_W-1:0]       win_idx;

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) gnt_idx = IDX_W'(i);
    end
  end

  assign gnt_any    = |grant_q;
  assign cur_req    = gnt_any & bus.m_req_i[gnt_idx];
  assign others_req = |(bus.m_req_i & ~grant_q);
  assign force_rot  = (MAX_BURST != 0) && cur_req && (burst_cnt_q == CNT_CAP) && others_req;
  assign cand       = force_rot ? (bus.m_req_i & ~grant_q) : bus.m_req_i;

  // Winner selection among candidate requesters.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
`ifdef RIB_RR_EN
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      int unsigned      j;
      logic [IDX_W-1:0] jj;
      j = 32'(last_q) + 1 + k;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      jj = IDX_W'(j);
      if (!win_vld && cand[jj]) begin
        win_vld = 1'b1;
        win_idx = jj;
      end
    end
`else
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (!win_vld && cand[k]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(k);
      end
    end
`endif
  end

  always_comb begin
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
`ifdef RIB_RR_EN
    last_d      = last_q;
`endif
    if (!cur_req || force_rot) begin
      grant_d = '0;
      if (win_vld) begin
        grant_d[win_idx] = 1'b1;
`ifdef RIB_RR_EN
        last_d = win_idx;
`endif
      end
    end
    if (grant_d != grant_q) begin
      burst_cnt_d = '0;
    end else if (cur_req && (burst_cnt_q != CNT_CAP)) begin
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q     <= '0;
      burst_cnt_q <= '0;
`ifdef RIB_RR_EN
      last_q      <= IDX_W'(NUM_MASTERS - 1);
`endif
    end else begin
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
`ifdef RIB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              g_we;
  logic [SEL_W-1:0]  sel;
  logic              sel_ok;
  logic [DATA_W-1:0] rdata;

  assign g_addr  = bus.m_addr_i[gnt_idx*ADDR_W +: ADDR_W];
  assign g_wdata = bus.m_data_i[gnt_idx*DATA_W +: DATA_W];
  assign g_we    = bus.m_we_i[gnt_idx];
  assign sel     = g_addr[ADDR_W-1 -: SEL_W];
  assign sel_ok  = 32'(sel) < NUM_SLAVES;

  // Fan-out to slaves and read-data return; an out-of-range sel matches no slave.
  always_comb begin
    bus.s_addr_o = '0;
    bus.s_data_o = '0;
    bus.s_we_o   = '0;
    bus.m_data_o = '0;
    rdata        = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (gnt_any) begin
        bus.s_addr_o[k*ADDR_W +: ADDR_W] = {SEL_W'(0), g_addr[LOW_W-1:0]};
        bus.s_data_o[k*DATA_W +: DATA_W] = g_wdata;
      end
      if (32'(sel) == k) begin
        bus.s_we_o[k] = cur_req & g_we;
        rdata         = bus.s_data_i[k*DATA_W +: DATA_W];
      end
    end
    if (gnt_any) bus.m_data_o[gnt_idx*DATA_W +: DATA_W] = rdata;
  end

  assign bus.grant_o     = grant_q;
  assign bus.dec_err_o   = cur_req & ~sel_ok;
  assign bus.hold_flag_o = |(bus.m_req_i & ~grant_q);
endmodule

// File: tb/tb_rib_xbar.sv
// Directed bench for rib_xbar: three instances (MAX_BURST 4, 0, 1) share master stimulus.
module tb_rib_xbar;
  localparam int unsigned NM = 4;
  localparam int unsigned NS = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_we;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_data;

  rib_xbar_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
  rib_xbar_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus_b ();
  rib_xbar_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus_c ();

  assign bus_a.m_req_i  = m_req;
  assign bus_a.m_we_i   = m_we;
  assign bus_a.m_addr_i = m_addr;
  assign bus_a.m_data_i = m_data;
  assign bus_b.m_req_i  = m_req;
  assign bus_b.m_we_i   = m_we;
  assign bus_b.m_addr_i = m_addr;
  assign bus_b.m_data_i = m_data;
  assign bus_c.m_req_i  = m_req;
  assign bus_c.m_we_i   = m_we;
  assign bus_c.m_addr_i = m_addr;
  assign bus_c.m_data_i = m_data;
  assign bus_b.s_data_i = '0;
  assign bus_c.s_data_i = '0;

  rib_xbar #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_W(4), .MAX_BURST(4))
    u_a (.clk(clk), .rst(rst), .bus(bus_a));
  rib_xbar #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_W(4), .MAX_BURST(0))
    u_b (.clk(clk), .rst(rst), .bus(bus_b));
  rib_xbar #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_W(4), .MAX_BURST(1))
    u_c (.clk(clk), .rst(rst), .bus(bus_c));

  // Small word-addressed memory behind every slave of instance A.
  for (genvar k = 0; k < NS; k++) begin : g_mem
    logic [DW-1:0] mem [16];
    logic [3:0]    widx;
    assign widx = bus_a.s_addr_o[k*AW+2 +: 4];
    assign bus_a.s_data_i[k*DW +: DW] = mem[widx];
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (bus_a.s_we_o[k]) begin
        mem[widx] <= bus_a.s_data_o[k*DW +: DW];
      end
    end
  end

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_v(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    checks++;
    assert (sbq.size() != 0) else begin
      failures++;
      $error("FAIL sb_empty observed=%h expected=<entry>", obs);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_m(input int m, input logic req, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req[m]            = req;
    m_we[m]             = we;
    m_addr[m*AW +: AW]  = a;
    m_data[m*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    m_req = '0;
    m_we  = '0;
    cyc();
    cyc();
    rst   = 1'b0;
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef RIB_RR_EN
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
    m_req = '0; m_we = '0; m_addr = '0; m_data = '0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    expect_v("rst_grant", 64'h0); expect_v("rst_hold", 64'h0); expect_v("rst_swe", 64'h0);
    expect_v("rst_burst", 64'h0); expect_v("rst_dec", 64'h0); expect_v("rst_saddr", 64'h0);
    mid();
    check(64'(bus_a.grant_o)); check(64'(bus_a.hold_flag_o)); check(64'(bus_a.s_we_o));
    check(64'(u_a.burst_cnt_q)); check(64'(bus_a.dec_err_o)); check(bus_a.s_addr_o[63:0]);

    // Single write then read back through master 1
    cyc();
    set_m(1, 1'b1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF);
    expect_v("wr_c0_grant", 64'h0); expect_v("wr_c0_hold", 64'h1);
    mid();
    check(64'(bus_a.grant_o)); check(64'(bus_a.hold_flag_o));
    cyc();
    expect_v("wr_grant", 64'h2); expect_v("wr_swe", 64'h2); expect_v("wr_saddr1", 64'h10);
    expect_v("wr_sdata1", 64'hDEAD_BEEF); expect_v("wr_dec", 64'h0);
    mid();
    check(64'(bus_a.grant_o)); check(64'(bus_a.s_we_o)); check(64'(bus_a.s_addr_o[1*AW +: AW]));
    check(64'(bus_a.s_data_o[1*DW +: DW])); check(64'(bus_a.dec_err_o));
    cyc();
    m_we[1] = 1'b0;
    expect_v("rd_data1", 64'hDEAD_BEEF); expect_v("rd_swe", 64'h0); expect_v("rd_data0", 64'h0);
    mid();
    check(64'(bus_a.m_data_o[1*DW +: DW])); check(64'(bus_a.s_we_o)); check(64'(bus_a.m_data_o[0 +: DW]));
    cyc();
    set_m(1, 1'b0, 1'b0, '0, '0);
    cyc();
    expect_v("wr_release", 64'h0);
    mid();
    check(64'(bus_a.grant_o));

    // Contention on the unlimited-burst instance
    do_reset();
    set_m(0, 1'b1, 1'b0, 32'h2000_0000, '0);
    set_m(2, 1'b1, 1'b0, 32'h3000_0004, '0);
    mid();
    cyc();
    expect_v("ct_grant0", 64'h1); expect_v("ct_hold", 64'h1);
    mid();
    check(64'(bus_b.grant_o)); check(64'(bus_b.hold_flag_o));
    for (int k = 2; k <= 6; k++) begin
      cyc();
      expect_v("ct_nolimit", 64'h1);
      mid();
      check(64'(bus_b.grant_o));
    end
    cyc();
    set_m(0, 1'b0, 1'b0, '0, '0);
    expect_v("ct_drop_grant", 64'h1); expect_v("ct_drop_hold", 64'h1);
    mid();
    check(64'(bus_b.grant_o)); check(64'(bus_b.hold_flag_o));
    cyc();
    expect_v("ct_handover", 64'h4); expect_v("ct_hold_clr", 64'h0);
    mid();
    check(64'(bus_b.grant_o)); check(64'(bus_b.hold_flag_o));

    // Burst limit of 4 on instance A
    do_reset();
    set_m(1, 1'b1, 1'b0, 32'h1000_0000, '0);
    set_m(3, 1'b1, 1'b0, 32'h0000_0000, '0);
    mid();
    for (int k = 1; k <= 5; k++) begin
      cyc();
      expect_v($sformatf("burst_c%0d", k), (k <= 4) ? 64'h2 : 64'h8);
      mid();
      check(64'(bus_a.grant_o));
    end
    expect_v("burst_hold", 64'h1);
    check(64'(bus_a.hold_flag_o));

    // Arbitration order with MAX_BURST=1, all masters requesting
    do_reset();
    for (int m = 0; m < 4; m++) set_m(m, 1'b1, 1'b0, 32'h0000_0000, '0);
    mid();
    for (int k = 1; k <= 5; k++) begin
      cyc();
      expect_v($sformatf("rr_c%0d", k), 64'(rr_exp[k-1]));
      mid();
      check(64'(bus_c.grant_o));
    end

    // Decode error to a nonexistent slave
    do_reset();
    set_m(2, 1'b1, 1'b1, 32'hF000_0000, 32'h1234_5678);
    expect_v("de_c0_swe", 64'h0);
    mid();
    check(64'(bus_a.s_we_o));
    cyc();
    expect_v("de_grant", 64'h4); expect_v("de_err", 64'h1); expect_v("de_swe", 64'h0);
    mid();
    check(64'(bus_a.grant_o)); check(64'(bus_a.dec_err_o)); check(64'(bus_a.s_we_o));
    cyc();
    m_we[2] = 1'b0;
    expect_v("de_rd_err", 64'h1); expect_v("de_rd_data", 64'h0); expect_v("de_rd_swe", 64'h0);
    mid();
    check(64'(bus_a.dec_err_o)); check(64'(bus_a.m_data_o[2*DW +: DW])); check(64'(bus_a.s_we_o));
    cyc();
    m_req[2] = 1'b0;
    expect_v("de_noxfer_grant", 64'h4); expect_v("de_noxfer_err", 64'h0);
    mid();
    check(64'(bus_a.grant_o)); check(64'(bus_a.dec_err_o));

    // Reset during a granted write burst
    do_reset();
    set_m(0, 1'b1, 1'b1, 32'h1000_0020, 32'hCAFE_F00D);
    mid();
    cyc();
    expect_v("rm_grant", 64'h1);
    mid();
    check(64'(bus_a.grant_o));
    cyc();
    rst = 1'b1;
    expect_v("rm_rst_swe", 64'h2); expect_v("rm_rst_grant", 64'h1);
    mid();
    check(64'(bus_a.s_we_o)); check(64'(bus_a.grant_o));
    cyc();
    rst = 1'b0;
    expect_v("rm_post_grant", 64'h0); expect_v("rm_post_burst", 64'h0);
    expect_v("rm_post_dec", 64'h0); expect_v("rm_post_hold", 64'h1);
    mid();
    check(64'(bus_a.grant_o)); check(64'(u_a.burst_cnt_q));
    check(64'(bus_a.dec_err_o)); check(64'(bus_a.hold_flag_o));
    cyc();
    expect_v("rm_regrant", 64'h1);
    mid();
    check(64'(bus_a.grant_o));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
